dmem_resp_unit: RTL

DMEM_RESP_UNIT -- requirements
Module: dmem_resp_unit

---
 rtl/dmem_resp_unit_if.sv | 32 +++
 rtl/dmem_resp_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_resp_unit_if.sv
// Request/response bundle between a core-side requester and the data memory
// response unit. Signal names carry the unit's view of direction.
interface dmem_resp_unit_if;
    logic        dmem_req_valid_i;
    logic [4:0]  dmem_req_cmd_i;
    logic [39:0] dmem_req_addr_i;
    logic [63:0] dmem_req_data_i;
    logic [2:0]  dmem_op_type_i;
    logic [7:0]  dmem_req_tag_i;
    logic        dmem_req_kill_i;
    logic        dmem_req_ready_o;
    logic        dmem_resp_valid_o;
    logic [63:0] dmem_resp_data_o;
    logic [7:0]  dmem_resp_tag_o;
    logic        dmem_resp_nack_o;
    logic        dmem_xcpt_ma_ld_o;
    logic        dmem_xcpt_ma_st_o;

    modport master (
        output dmem_req_valid_i, dmem_req_cmd_i, dmem_req_addr_i, dmem_req_data_i,
               dmem_op_type_i, dmem_req_tag_i, dmem_req_kill_i,
        input  dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_data_o, dmem_resp_tag_o,
               dmem_resp_nack_o, dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o
    );

    modport slave (
        input  dmem_req_valid_i, dmem_req_cmd_i, dmem_req_addr_i, dmem_req_data_i,
               dmem_op_type_i, dmem_req_tag_i, dmem_req_kill_i,
        output dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_data_o, dmem_resp_tag_o,
               dmem_resp_nack_o, dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o
    );
endinterface

// File: rtl/dmem_resp_unit.sv
// Fixed-latency data memory with one request in flight at a time.
//
// state | meaning
// IDLE  | ready for a new request
// BUSY  | request latched, latency counter running
// RESP  | response cycle: memory read/write and one-cycle resp_valid
module dmem_resp_unit #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_resp_unit_if.slave  bus
);
    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic        accept, resp_fire;

    logic [4:0]  cmd_q;
    logic [39:0] addr_q;
    logic [63:0] data_q;
    logic [2:0]  op_q;
    logic [7:0]  tag_q;

    logic [63:0] mem [MEM_WORDS];

    logic          is_load, is_store, out_of_range, nack, misaligned;
    logic          resp_valid, write_en;
    logic [AW-1:0] widx;
    logic [63:0]   rd_word, shifted, ld_data, wdata;
    logic [7:0]    bmask;

    // State register and latency down-counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, counter load/decrement, kill handling
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        resp_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dmem_req_valid_i) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (bus.dmem_req_kill_i) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 3'd1;
                    if (cnt == 3'd1) state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                resp_fire  = ~bus.dmem_req_kill_i;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the accepted request
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            cmd_q  <= bus.dmem_req_cmd_i;
            addr_q <= bus.dmem_req_addr_i;
            data_q <= bus.dmem_req_data_i;
            op_q   <= bus.dmem_op_type_i;
            tag_q  <= bus.dmem_req_tag_i;
        end
    end

    // Decode, load extraction and store byte lanes from the latched request
    always_comb begin
        is_load      = (cmd_q == 5'd0);
        is_store     = (cmd_q == 5'd1);
        out_of_range = (addr_q[39:3] >= 37'(MEM_WORDS));
        nack         = ~(is_load | is_store) | out_of_range;
        case (op_q[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr_q[0];
            2'd2:    misaligned = |addr_q[1:0];
            default: misaligned = |addr_q[2:0];
        endcase
        widx    = addr_q[3 +: AW];
        rd_word = mem[widx];
        shifted = rd_word >> {addr_q[2:0], 3'b000};
        case (op_q[1:0])
            2'd0:    ld_data = op_q[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    ld_data = op_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    ld_data = op_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ld_data = shifted;
        endcase
        case (op_q[1:0])
            2'd0:    bmask = 8'h01;
            2'd1:    bmask = 8'h03;
            2'd2:    bmask = 8'h0F;
            default: bmask = 8'hFF;
        endcase
        bmask = 8'(bmask << addr_q[2:0]);
        wdata = data_q << {addr_q[2:0], 3'b000};
    end

    // Reset in the response cycle suppresses both the pulse and the write
    assign resp_valid = resp_fire & ~rst_i;
    assign write_en   = resp_valid & is_store & ~nack & ~misaligned;

    // Byte-masked store commit in the response cycle
    always_ff @(posedge clk_i) begin
        if (write_en) begin
            for (int b = 0; b < 8; b++) begin
                if (bmask[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign bus.dmem_req_ready_o  = (state == IDLE);
    assign bus.dmem_resp_valid_o = resp_valid;
    assign bus.dmem_resp_data_o  = (resp_valid & is_load & ~nack & ~misaligned) ? ld_data : 64'd0;
    assign bus.dmem_resp_tag_o   = resp_valid ? tag_q : 8'd0;
    assign bus.dmem_resp_nack_o  = resp_valid & nack;
    assign bus.dmem_xcpt_ma_ld_o = resp_valid & ~nack & misaligned & is_load;
    assign bus.dmem_xcpt_ma_st_o = resp_valid & ~nack & misaligned & is_store;
endmodule
